// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the default slave: response codes, FSM state
// types and a saturating increment used by the optional error log.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_default_slave_rd.sv
// Read side of the AXI4 default slave: accepts AR and streams ARLEN+1
// DECERR beats with RLAST on the final one. All outputs are registered.
module axi4_default_slave_rd
  import axi4_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  rd_state_t  rd_state;
  logic [7:0] beats_left;

  // The slave never returns real data.
  assign rdata = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state   <= R_IDLE;
      beats_left <= 8'd0;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
      rresp      <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rd_state   <= R_DATA;
            arready    <= 1'b0;
            rvalid     <= 1'b1;
            rid        <= arid;
            rresp      <= RESP_DECERR;
            beats_left <= arlen;
            rlast      <= (arlen == 8'd0);
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rd_state <= R_IDLE;
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
            end else begin
              // rlast is pre-computed so it is registered on the final beat;
              // the counter only moves while nonzero, so it cannot wrap.
              beats_left <= beats_left - 8'd1;
              rlast      <= (beats_left == 8'd1);
            end
          end
        end
        default: begin
          rd_state <= R_IDLE;
          arready  <= 1'b0;
          rvalid   <= 1'b0;
          rlast    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi4_default_slave.sv
// AXI4 crossbar default slave: completes unmapped AW/AR with DECERR.
// Optional error log ports enabled by AXI4_DEFAULT_SLAVE_ERR_LOG_EN.
module axi4_default_slave
  import axi4_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
  ,
  output logic [15:0]           err_wr_cnt,
  output logic [15:0]           err_rd_cnt,
  output logic [ADDR_WIDTH-1:0] err_last_addr
`endif
);

  wr_state_t wr_state;
  logic      unused_inputs;

  // Write path: accept AW, swallow beats until wlast, then one B beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            wr_state <= W_DATA;
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid && wready && wlast) begin
            wr_state <= W_RESP;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= RESP_DECERR;
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            wr_state <= W_IDLE;
            bvalid   <= 1'b0;
            awready  <= 1'b1;
          end
        end
        default: begin
          wr_state <= W_IDLE;
          awready  <= 1'b0;
          wready   <= 1'b0;
          bvalid   <= 1'b0;
        end
      endcase
    end
  end

  axi4_default_slave_rd #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .arid    (arid),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
  // Burst length is never checked; wlast alone terminates the write.
  assign unused_inputs = ^awlen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_wr_cnt    <= 16'd0;
      err_rd_cnt    <= 16'd0;
      err_last_addr <= '0;
    end else begin
      if (awvalid && awready) err_wr_cnt <= sat_inc16(err_wr_cnt);
      if (arvalid && arready) err_rd_cnt <= sat_inc16(err_rd_cnt);
      if (arvalid && arready) begin
        err_last_addr <= araddr;
      end else if (awvalid && awready) begin
        err_last_addr <= awaddr;
      end
    end
  end
`else
  assign unused_inputs = ^{awlen, awaddr, araddr};
`endif

endmodule

// File: tb/tb_axi4_default_slave.sv
// Self-checking bench for axi4_default_slave: directed steps with random
// ids/addresses/lengths/back-pressure checked against a transaction-level model.
module tb_axi4_default_slave;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic           awvalid, awready, wlast, wvalid, wready;
  logic [1:0]     bresp, rresp;
  logic           bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]  rdata;
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
  logic [15:0]    err_wr_cnt, err_rd_cnt;
  logic [AW-1:0]  err_last_addr;
`endif

  always #5 clk = ~clk;

  axi4_default_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
    , .err_wr_cnt(err_wr_cnt), .err_rd_cnt(err_rd_cnt), .err_last_addr(err_last_addr)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model of the error log.
  int            exp_wr = 0;
  int            exp_rd = 0;
  logic [AW-1:0] exp_addr = '0;

  // Bus monitor: handshake counts and received B/R beats.
  int             cyc = 0;
  int             aw_hs = 0, w_hs = 0, ar_hs = 0, ar_cyc = 0, r_unstable = 0;
  logic [IDW-1:0] b_id_q[$];
  logic [1:0]     b_resp_q[$];
  logic [IDW-1:0] r_id_q[$];
  logic [1:0]     r_resp_q[$];
  logic           r_last_q[$];
  logic [DW-1:0]  r_data_q[$];
  int             r_cyc_q[$];
  logic           hold;
  logic [IDW-1:0] h_id;
  logic [DW-1:0]  h_data;
  logic [1:0]     h_resp;
  logic           h_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      hold <= 1'b0;
    end else begin
      if (awvalid && awready) aw_hs <= aw_hs + 1;
      if (wvalid && wready) w_hs <= w_hs + 1;
      if (bvalid && bready) begin
        b_id_q.push_back(bid);
        b_resp_q.push_back(bresp);
      end
      if (arvalid && arready) begin
        ar_hs  <= ar_hs + 1;
        ar_cyc <= cyc;
      end
      if (rvalid && rready) begin
        r_id_q.push_back(rid);
        r_resp_q.push_back(rresp);
        r_last_q.push_back(rlast);
        r_data_q.push_back(rdata);
        r_cyc_q.push_back(cyc);
      end
      if (hold && (!rvalid || rid !== h_id || rdata !== h_data || rresp !== h_resp || rlast !== h_last))
        r_unstable <= r_unstable + 1;
      hold   <= rvalid && !rready;
      h_id   <= rid;
      h_data <= rdata;
      h_resp <= rresp;
      h_last <= rlast;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err();
`ifdef AXI4_DEFAULT_SLAVE_ERR_LOG_EN
    chk("err_wr_cnt", longint'(err_wr_cnt), longint'(exp_wr));
    chk("err_rd_cnt", longint'(err_rd_cnt), longint'(exp_rd));
    chk("err_last_addr", longint'(err_last_addr), longint'(exp_addr));
`endif
  endtask

  // One write transaction of nbeats W beats; pre_w offers W before AW.
  task automatic wr_txn(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                        input int nbeats, input bit pre_w);
    int b0, a0, w0, t;
    b0 = b_id_q.size(); a0 = aw_hs; w0 = w_hs;
    if (pre_w) begin
      wvalid = 1'b1;
      wlast  = (nbeats == 1);
      repeat (2) begin
        @(negedge clk);
        chk("w_stall_wready", longint'(wready), 0);
      end
      chk("w_stall_no_hs", longint'(w_hs - w0), 0);
    end
    awid = id; awaddr = addr; awlen = 8'(nbeats - 1); awvalid = 1'b1;
    t = 0;
    while (aw_hs == a0 && t < 50) begin @(negedge clk); t++; end
    chk("aw_hs", longint'(aw_hs - a0), 1);
    awvalid = 1'b0;
    exp_wr++; exp_addr = addr;
    chk("wready_after_aw", longint'(wready), 1);
    for (int i = 0; i < nbeats; i++) begin
      if (!(pre_w && i == 0)) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wvalid = 1'b1;
        wlast  = (i == nbeats - 1);
      end
      t = 0;
      while (w_hs - w0 <= i && t < 50) begin @(negedge clk); t++; end
      chk("w_beat_hs", longint'(w_hs - w0), longint'(i + 1));
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_wlast", longint'(bvalid), 1);
    chk("wready_after_wlast", longint'(wready), 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("b_stall_valid", longint'(bvalid), 1);
      chk("b_stall_bid", longint'(bid), longint'(id));
    end
    bready = 1'b1;
    t = 0;
    while (b_id_q.size() == b0 && t < 50) begin @(negedge clk); t++; end
    bready = 1'b0;
    chk("b_count", longint'(b_id_q.size() - b0), 1);
    if (b_id_q.size() > b0) begin
      chk("bid", longint'(b_id_q[b0]), longint'(id));
      chk("bresp", longint'(b_resp_q[b0]), 64'h3);
    end
    chk("awready_after_b", longint'(awready), 1);
    @(negedge clk);
    chk("bvalid_after_b", longint'(bvalid), 0);
  endtask

  // One read transaction; rnd_ready toggles rready randomly (about 50%).
  task automatic rd_txn(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input bit rnd_ready);
    int s, a0, t, n_exp;
    s = r_id_q.size(); a0 = ar_hs; n_exp = int'(len) + 1;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    t = 0;
    while (ar_hs == a0 && t < 50) begin @(negedge clk); t++; end
    chk("ar_hs", longint'(ar_hs - a0), 1);
    arvalid = 1'b0;
    exp_rd++; exp_addr = addr;
    chk("rvalid_after_ar", longint'(rvalid), 1);
    t = 0;
    while (r_id_q.size() - s < n_exp && t < 3000) begin
      rready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    @(negedge clk);
    chk("r_beats", longint'(r_id_q.size() - s), longint'(n_exp));
    chk("rvalid_after_last", longint'(rvalid), 0);
    chk("arready_after_last", longint'(arready), 1);
    for (int k = 0; k < n_exp && s + k < r_id_q.size(); k++) begin
      chk("rid", longint'(r_id_q[s+k]), longint'(id));
      chk("rresp", longint'(r_resp_q[s+k]), 64'h3);
      chk("rdata", longint'(r_data_q[s+k]), 0);
      chk("rlast", longint'(r_last_q[s+k]), longint'(k == n_exp - 1));
      if (!rnd_ready) chk("r_beat_cycle", longint'(r_cyc_q[s+k]), longint'(ar_cyc + 1 + k));
    end
  endtask

  initial begin
    int a0, r0, w0, bs, rs, t;
    logic [AW-1:0] ad_w, ad_r;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", longint'(awready), 0);
    chk("rst_arready", longint'(arready), 0);
    chk("rst_wready", longint'(wready), 0);
    chk("rst_bvalid", longint'(bvalid), 0);
    chk("rst_rvalid", longint'(rvalid), 0);
    chk("rst_rlast", longint'(rlast), 0);
    chk("rst_bid", longint'(bid), 0);
    chk("rst_rid", longint'(rid), 0);
    chk("rst_rdata", longint'(rdata), 0);
    chk("rst_bresp", longint'(bresp), 0);
    chk("rst_rresp", longint'(rresp), 0);
    chk_err();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", longint'(awready), 1);
    chk("post_rst_arready", longint'(arready), 1);
    chk("post_rst_wready", longint'(wready), 0);

    // Single-beat write, id 3
    wr_txn(4'd3, $urandom, 1, 1'b0);
    // Four-beat read, id 5, rready held high
    rd_txn(4'd5, $urandom, 8'd3, 1'b0);
    // 256-beat read with random back-pressure
    rd_txn(4'($urandom), $urandom, 8'd255, 1'b1);
    chk("r_stable_while_stalled", longint'(r_unstable), 0);
    // W offered before AW
    wr_txn(4'($urandom), $urandom, int'($urandom_range(1, 4)), 1'b1);
    chk_err();

    // Concurrent AW and AR, both len 1
    a0 = aw_hs; r0 = ar_hs; w0 = w_hs; bs = b_id_q.size(); rs = r_id_q.size();
    ad_w = $urandom; ad_r = $urandom;
    awid = 4'd6; awaddr = ad_w; awlen = 8'd1; awvalid = 1'b1;
    arid = 4'd9; araddr = ad_r; arlen = 8'd1; arvalid = 1'b1;
    @(negedge clk);
    chk("cc_aw_hs", longint'(aw_hs - a0), 1);
    chk("cc_ar_hs", longint'(ar_hs - r0), 1);
    awvalid = 1'b0; arvalid = 1'b0;
    exp_wr++; exp_rd++; exp_addr = ad_r;
    rready = 1'b1; bready = 1'b1; wvalid = 1'b1; wlast = 1'b0;
    t = 0;
    while (!(b_id_q.size() - bs == 1 && r_id_q.size() - rs == 2) && t < 30) begin
      @(negedge clk);
      if (w_hs - w0 == 1) wlast = 1'b1;
      if (w_hs - w0 >= 2) begin wvalid = 1'b0; wlast = 1'b0; end
      t++;
    end
    rready = 1'b0; bready = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("cc_w_beats", longint'(w_hs - w0), 2);
    chk("cc_b_count", longint'(b_id_q.size() - bs), 1);
    chk("cc_r_count", longint'(r_id_q.size() - rs), 2);
    if (b_id_q.size() > bs) chk("cc_bid", longint'(b_id_q[bs]), 6);
    if (r_id_q.size() >= rs + 2) begin
      chk("cc_rid", longint'(r_id_q[rs+1]), 9);
      chk("cc_rlast0", longint'(r_last_q[rs]), 0);
      chk("cc_rlast1", longint'(r_last_q[rs+1]), 1);
    end
    chk_err();

    // Random mix
    for (int i = 0; i < 4; i++) begin
      wr_txn(4'($urandom), $urandom, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      rd_txn(4'($urandom), $urandom, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    chk("r_stable_while_stalled_mix", longint'(r_unstable), 0);
    chk_err();

    // Reset during beat 2 of an 8-beat read
    rs = r_id_q.size(); r0 = ar_hs;
    arid = 4'd2; araddr = $urandom; arlen = 8'd7; arvalid = 1'b1;
    t = 0;
    while (ar_hs == r0 && t < 50) begin @(negedge clk); t++; end
    arvalid = 1'b0;
    rready = 1'b1;
    t = 0;
    while (r_id_q.size() - rs < 1 && t < 50) begin @(negedge clk); t++; end
    chk("rst_mid_beat2_valid", longint'(rvalid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", longint'(rvalid), 0);
    chk("rst_mid_arready", longint'(arready), 0);
    chk("rst_mid_rlast", longint'(rlast), 0);
    exp_wr = 0; exp_rd = 0; exp_addr = '0;
    chk_err();
    rst_n = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("rst_mid_beats_taken", longint'(r_id_q.size() - rs), 1);
    chk("rst_rel_arready", longint'(arready), 1);
    chk("rst_rel_awready", longint'(awready), 1);
    chk("rst_rel_rvalid", longint'(rvalid), 0);
    rd_txn(4'($urandom), $urandom, 8'($urandom_range(0, 7)), 1'b0);
    chk_err();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
